// File: rtl/shadow_tracer_pkg.sv
// Shared types for the shadow tracer lockstep checker: FSM state enum,
// default-width history sample layout and the sample width helper.
package shadow_tracer_pkg;

  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_POST_TRIG,
    ST_FROZEN
  } tracer_state_e;

  typedef struct packed {
    logic                  phase;
    logic                  ok;
    logic [DEF_CTRL_W-1:0] ctrl_exp;
    logic [DEF_CTRL_W-1:0] ctrl_act;
    logic [DEF_ADDR_W-1:0] addr_act;
    logic [DEF_DATA_W-1:0] data_exp;
    logic [DEF_DATA_W-1:0] data_act;
  } sample_t;

  function automatic int unsigned sample_width(input int unsigned ctrl_w,
                                               input int unsigned addr_w,
                                               input int unsigned data_w);
    return 2 + 2 * ctrl_w + addr_w + 2 * data_w;
  endfunction

  localparam int unsigned SAMPLE_W = sample_width(DEF_CTRL_W, DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/shadow_lockstep_checker_if.sv
// Compare bus between shadow core / bus pins and the lockstep checker:
// strobe, expected/actual groups and per-group waivers.
interface shadow_lockstep_checker_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              sample_en;
  logic              phase;
  logic              in_reset;
  logic [CTRL_W-1:0] ctrl_exp;
  logic [CTRL_W-1:0] ctrl_act;
  logic [ADDR_W-1:0] addr_exp;
  logic [ADDR_W-1:0] addr_act;
  logic [DATA_W-1:0] data_exp;
  logic [DATA_W-1:0] data_act;
  logic              drive_en;
  logic              bus_cycle;
  logic              ign_ctrl;
  logic              ign_addr;
  logic              ign_data;

  modport master (
    output sample_en, phase, in_reset, ctrl_exp, ctrl_act, addr_exp, addr_act,
           data_exp, data_act, drive_en, bus_cycle, ign_ctrl, ign_addr, ign_data
  );

  modport slave (
    input sample_en, phase, in_reset, ctrl_exp, ctrl_act, addr_exp, addr_act,
          data_exp, data_act, drive_en, bus_cycle, ign_ctrl, ign_addr, ign_data
  );
endinterface

// File: rtl/shadow_hist_ring.sv
// History ring storage: simple dual-port RAM, one write port and a
// registered read port (read port register cleared by reset only).
module shadow_hist_ring #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 50,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/shadow_lockstep_checker.sv
// Lockstep comparator with sticky/counted mismatches and a trigger-frozen
// history ring. Define SHADOW_TRACER_ADDR_CMP_EN to include the address group.
module shadow_lockstep_checker
  import shadow_tracer_pkg::*;
#(
  parameter  int unsigned CTRL_W     = 8,
  parameter  int unsigned ADDR_W     = 16,
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned HIST_DEPTH = 16,
  parameter  int unsigned POST_DEPTH = 4,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned IW         = $clog2(HIST_DEPTH),
  localparam int unsigned SW         = sample_width(CTRL_W, ADDR_W, DATA_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  shadow_lockstep_checker_if.slave  cmp,
  input  logic                      clear,
  output logic                      match,
  output logic                      sticky_mm,
  output logic [CNT_W-1:0]          mm_count,
  output logic                      frozen,
  output logic [IW-1:0]             trig_idx,
  output logic [IW:0]               hist_fill,
  input  logic [IW-1:0]             rd_idx,
  output logic [SW-1:0]             rd_data
);
  localparam logic [IW:0] FILL_FULL = (IW + 1)'(HIST_DEPTH);

  tracer_state_e state, state_next;
  logic          addr_ok, ok, mm_event;
  logic          wr_en, trig_load;
  logic          rise_ok, fall_ok;
  logic [IW-1:0] wr_ptr, trig_ptr, oldest, post_cnt, post_next;
  logic [SW-1:0] wr_word;

`ifdef SHADOW_TRACER_ADDR_CMP_EN
  assign addr_ok = (cmp.addr_exp == cmp.addr_act) | cmp.ign_addr;
`else
  logic addr_exp_unused;
  assign addr_exp_unused = ^cmp.addr_exp;
  assign addr_ok = 1'b1;
`endif

  assign ok = cmp.in_reset
            | (((cmp.ctrl_exp == cmp.ctrl_act) | cmp.ign_ctrl)
               & ((cmp.data_exp == cmp.data_act) | ~cmp.drive_en | ~cmp.bus_cycle | cmp.ign_data)
               & addr_ok);

  // clear beats a coincident strobe: the sample is neither stored nor counted
  assign mm_event = cmp.sample_en & ~clear & ~ok;
  assign wr_word  = {cmp.phase, ok, cmp.ctrl_exp, cmp.ctrl_act, cmp.addr_act,
                     cmp.data_exp, cmp.data_act};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    post_next  = post_cnt;
    wr_en      = 1'b0;
    trig_load  = 1'b0;
    if (clear) begin
      state_next = ST_ARMED;
      post_next  = '0;
    end else if (cmp.sample_en) begin
      case (state)
        ST_ARMED: begin
          wr_en = 1'b1;
          if (!ok) begin
            trig_load = 1'b1;
            if (POST_DEPTH == 0) begin
              state_next = ST_FROZEN;
            end else begin
              state_next = ST_POST_TRIG;
              post_next  = IW'(POST_DEPTH);
            end
          end
        end
        ST_POST_TRIG: begin
          wr_en     = 1'b1;
          post_next = post_cnt - IW'(1);
          if (post_cnt == IW'(1)) state_next = ST_FROZEN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      post_cnt  <= '0;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      hist_fill <= '0;
      rise_ok   <= 1'b1;
      fall_ok   <= 1'b1;
      sticky_mm <= 1'b0;
      mm_count  <= '0;
    end else if (clear) begin
      post_cnt  <= '0;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      hist_fill <= '0;
      rise_ok   <= 1'b1;
      fall_ok   <= 1'b1;
      sticky_mm <= 1'b0;
      mm_count  <= '0;
    end else begin
      post_cnt <= post_next;
      if (cmp.sample_en) begin
        if (cmp.phase) fall_ok <= ok;
        else           rise_ok <= ok;
      end
      if (mm_event) begin
        sticky_mm <= 1'b1;
        if (mm_count != '1) mm_count <= mm_count + CNT_W'(1);
      end
      if (trig_load) trig_ptr <= wr_ptr;
      if (wr_en) begin
        wr_ptr <= wr_ptr + IW'(1);
        if (hist_fill != FILL_FULL) hist_fill <= hist_fill + (IW + 1)'(1);
      end
    end
  end

  assign match    = rise_ok & fall_ok;
  assign frozen   = (state == ST_FROZEN);
  assign oldest   = (hist_fill == FILL_FULL) ? wr_ptr : '0;
  assign trig_idx = frozen ? (trig_ptr - oldest) : '0;

  shadow_hist_ring #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (SW)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_addr (oldest + rd_idx),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_shadow_lockstep_checker.sv
// Scoreboard bench for shadow_lockstep_checker: a default instance and a
// 4-bit-counter instance share one compare bus.
module tb_shadow_lockstep_checker;
  import shadow_tracer_pkg::*;

  localparam int unsigned HD = 16;
  localparam int unsigned PD = 4;
  localparam int unsigned SW = sample_width(8, 16, 8);

  logic          clk;
  logic          reset;
  logic          clear;
  logic [3:0]    rd_idx;
  logic          match, sticky_mm, frozen;
  logic [15:0]   mm_count;
  logic [3:0]    trig_idx;
  logic [4:0]    hist_fill;
  logic [SW-1:0] rd_data;
  logic          s_match, s_sticky_mm, s_frozen;
  logic [3:0]    s_mm_count;
  logic [3:0]    s_trig_idx;
  logic [4:0]    s_hist_fill;
  logic [SW-1:0] s_rd_data;

  shadow_lockstep_checker_if #(.CTRL_W(8), .ADDR_W(16), .DATA_W(8)) cmp ();

  shadow_lockstep_checker #(
    .CTRL_W(8), .ADDR_W(16), .DATA_W(8), .HIST_DEPTH(HD), .POST_DEPTH(PD), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cmp(cmp), .clear(clear), .match(match),
    .sticky_mm(sticky_mm), .mm_count(mm_count), .frozen(frozen), .trig_idx(trig_idx),
    .hist_fill(hist_fill), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  shadow_lockstep_checker #(
    .CTRL_W(8), .ADDR_W(16), .DATA_W(8), .HIST_DEPTH(HD), .POST_DEPTH(PD), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .cmp(cmp), .clear(clear), .match(s_match),
    .sticky_mm(s_sticky_mm), .mm_count(s_mm_count), .frozen(s_frozen), .trig_idx(s_trig_idx),
    .hist_fill(s_hist_fill), .rd_idx(rd_idx), .rd_data(s_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic match;
    logic sticky;
    int   count;
    logic frozen;
    int   fill;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            m_state, m_wr, m_fill, m_post, m_trig, m_cnt;
  logic          m_rise, m_fall, m_sticky;
  logic [SW-1:0] m_ring [HD];
  logic          ph;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_wr = 0; m_fill = 0; m_post = 0; m_trig = 0; m_cnt = 0;
    m_rise = 1'b1; m_fall = 1'b1; m_sticky = 1'b0;
  endtask

  function automatic int m_oldest();
    return (m_fill == HD) ? m_wr : 0;
  endfunction

  function automatic logic model_ok();
    logic aok;
`ifdef SHADOW_TRACER_ADDR_CMP_EN
    aok = (cmp.addr_exp == cmp.addr_act) || cmp.ign_addr;
`else
    aok = 1'b1;
`endif
    if (cmp.in_reset) return 1'b1;
    if (cmp.ctrl_exp != cmp.ctrl_act && !cmp.ign_ctrl) return 1'b0;
    if (cmp.data_exp != cmp.data_act && cmp.drive_en && cmp.bus_cycle && !cmp.ign_data)
      return 1'b0;
    return aok;
  endfunction

  task automatic set_bus();
    cmp.ctrl_exp = 8'($urandom);
    cmp.addr_exp = 16'($urandom);
    cmp.data_exp = 8'($urandom);
    cmp.ctrl_act = cmp.ctrl_exp;
    cmp.addr_act = cmp.addr_exp;
    cmp.data_act = cmp.data_exp;
    cmp.drive_en = 1'b1; cmp.bus_cycle = 1'b1; cmp.in_reset = 1'b0;
    cmp.ign_ctrl = 1'b0; cmp.ign_addr = 1'b0; cmp.ign_data = 1'b0;
    cmp.phase = ph;
  endtask

  task automatic strobe(input logic do_clear);
    logic ok;
    exp_t e;
    @(negedge clk);
    cmp.sample_en = 1'b1;
    clear = do_clear;
    ok = model_ok();
    if (do_clear) begin
      model_reset();
    end else begin
      if (cmp.phase) m_fall = ok; else m_rise = ok;
      if (!ok) begin m_sticky = 1'b1; m_cnt++; end
      if (m_state != 2) begin
        m_ring[m_wr] = {cmp.phase, ok, cmp.ctrl_exp, cmp.ctrl_act, cmp.addr_act,
                        cmp.data_exp, cmp.data_act};
        if (m_state == 0 && !ok) begin
          m_trig = m_wr;
          if (PD == 0) m_state = 2;
          else begin m_state = 1; m_post = PD; end
        end else if (m_state == 1) begin
          m_post--;
          if (m_post == 0) m_state = 2;
        end
        m_wr = (m_wr + 1) % HD;
        if (m_fill < HD) m_fill++;
      end
    end
    sb.push_back('{m_rise && m_fall, m_sticky, m_cnt, m_state == 2, m_fill});
    ph = ~ph;
    @(posedge clk);
    #1;
    cmp.sample_en = 1'b0;
    clear = 1'b0;
    e = sb.pop_front();
    check_eq("match", 64'(match), 64'(e.match));
    check_eq("sticky_mm", 64'(sticky_mm), 64'(e.sticky));
    check_eq("mm_count", 64'(mm_count), 64'((e.count > 65535) ? 65535 : e.count));
    check_eq("mm_count_sat", 64'(s_mm_count), 64'((e.count > 15) ? 15 : e.count));
    check_eq("frozen", 64'(frozen), 64'(e.frozen));
    check_eq("hist_fill", 64'(hist_fill), 64'(e.fill));
  endtask

  task automatic run_ok(input int n);
    for (int i = 0; i < n; i++) begin
      set_bus();
      strobe(1'b0);
    end
  endtask

  // ctrl bit0 flipped on strobe 10 of n; ring assumed full beforehand
  task automatic run_trig(input int n);
    for (int s = 1; s <= n; s++) begin
      set_bus();
      if (s == 10) cmp.ctrl_act = cmp.ctrl_exp ^ 8'h01;
      strobe(1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_match"}, 64'(match), 64'(1));
    check_eq({tag, "_sticky"}, 64'(sticky_mm), 64'(0));
    check_eq({tag, "_count"}, 64'(mm_count), 64'(0));
    check_eq({tag, "_count_sat"}, 64'(s_mm_count), 64'(0));
    check_eq({tag, "_frozen"}, 64'(frozen), 64'(0));
    check_eq({tag, "_trig_idx"}, 64'(trig_idx), 64'(0));
    check_eq({tag, "_fill"}, 64'(hist_fill), 64'(0));
    check_eq({tag, "_rd_data"}, 64'(rd_data), 64'(0));
  endtask

  task automatic check_trigger(input string tag);
    sample_t s;
    int      exp_idx;
    exp_idx = (m_trig - m_oldest() + HD) % HD;
    check_eq({tag, "_frozen"}, 64'(frozen), 64'(1));
    check_eq({tag, "_trig_idx"}, 64'(trig_idx), 64'(11));
    check_eq({tag, "_trig_idx_model"}, 64'(trig_idx), 64'(exp_idx));
    rd_idx = 4'(11);
    @(posedge clk);
    #1;
    s = rd_data;
    check_eq({tag, "_rd_ok"}, 64'(s.ok), 64'(0));
    check_eq({tag, "_rd_data"}, 64'(rd_data), 64'(m_ring[(m_oldest() + 11) % HD]));
    rd_idx = 4'(12);
    @(posedge clk);
    #1;
    check_eq({tag, "_rd_next"}, 64'(rd_data), 64'(m_ring[(m_oldest() + 12) % HD]));
  endtask

  initial begin
    ph = 1'b0;
    reset = 1'b1;
    clear = 1'b0;
    rd_idx = '0;
    cmp.sample_en = 1'b0;
    set_bus();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // all groups equal, alternating phases
    run_ok(40);
    check_eq("t1_fill", 64'(hist_fill), 64'(16));
    check_eq("t1_count", 64'(mm_count), 64'(0));

    // trigger on strobe 10 with a full ring
    run_trig(20);
    check_eq("t2_sticky", 64'(sticky_mm), 64'(1));
    check_eq("t2_count", 64'(mm_count), 64'(1));
    check_trigger("t2");

    // data waivers
    set_bus();
    strobe(1'b1);
    set_bus(); cmp.data_act = ~cmp.data_exp; cmp.drive_en = 1'b0; strobe(1'b0);
    set_bus(); cmp.data_act = ~cmp.data_exp; cmp.ign_data = 1'b1; strobe(1'b0);
    set_bus(); cmp.data_act = ~cmp.data_exp; cmp.bus_cycle = 1'b0; strobe(1'b0);
    set_bus(); cmp.ctrl_act = ~cmp.ctrl_exp; cmp.in_reset = 1'b1; strobe(1'b0);
    check_eq("t3_waived_count", 64'(mm_count), 64'(0));
    set_bus(); cmp.data_act = ~cmp.data_exp; strobe(1'b0);
    check_eq("t3_count", 64'(mm_count), 64'(1));

    // address-only mismatch
    set_bus(); strobe(1'b1);
    set_bus(); cmp.addr_act = cmp.addr_exp ^ 16'h0100; strobe(1'b0);
`ifdef SHADOW_TRACER_ADDR_CMP_EN
    check_eq("t5_count", 64'(mm_count), 64'(1));
`else
    check_eq("t5_count", 64'(mm_count), 64'(0));
    check_eq("t5_match", 64'(match), 64'(1));
`endif

    // counter saturation, then clear coinciding with a mismatching strobe
    set_bus(); strobe(1'b1);
    for (int i = 0; i < 20; i++) begin
      set_bus(); cmp.ctrl_act = ~cmp.ctrl_exp; strobe(1'b0);
    end
    check_eq("t4_sat", 64'(s_mm_count), 64'(15));
    check_eq("t4_wide", 64'(mm_count), 64'(20));
    set_bus(); cmp.ctrl_act = ~cmp.ctrl_exp; strobe(1'b1);
    check_eq("t4_clr_count", 64'(mm_count), 64'(0));
    check_eq("t4_clr_sat", 64'(s_mm_count), 64'(0));
    check_eq("t4_clr_frozen", 64'(frozen), 64'(0));
    check_eq("t4_clr_sticky", 64'(sticky_mm), 64'(0));
    check_eq("t4_clr_match", 64'(match), 64'(1));

    // async reset while in POST_TRIG with a strobe in flight
    run_ok(16);
    run_trig(12);
    @(negedge clk);
    set_bus();
    cmp.ctrl_act = ~cmp.ctrl_exp;
    cmp.sample_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    @(posedge clk);
    #1;
    cmp.sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sb.delete();
    run_ok(16);
    run_trig(16);
    check_trigger("t6_rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
